// File: rtl/tchk_notifier_monitor.sv
// Timing-check notifier reader: synchronizes the notifier, counts its toggles as violations,
// stamps the first one since clear and raises an interrupt held until acknowledged.
module tchk_notifier_monitor #(
    parameter int CNT_W       = 8,
    parameter int TS_W        = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             notifier,
    input  logic             en,
    input  logic             clr,
    input  logic             irq_ack,
    output logic [CNT_W-1:0] viol_cnt,
    output logic             viol_sat,
    output logic [TS_W-1:0]  first_ts,
    output logic             ts_valid,
    output logic             irq
);

    typedef enum logic [1:0] {IDLE, ARMED, PENDING} state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_PRE = CNT_MAX - CNT_W'(1);

    state_t                 state;
    logic [SYNC_STAGES-1:0] sync_r;
    logic                   sync_q;
    logic                   prev;
    logic                   viol_evt;
    logic [TS_W-1:0]        ts_ctr;

    assign sync_q = sync_r[SYNC_STAGES-1];
    // prev follows sync_q even while disabled, so re-arming never sees a stale toggle.
    assign viol_evt = en & ~clr & (sync_q ^ prev);

    // NOTE: all state below uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_r <= '0;
            prev   <= 1'b0;
        end else begin
            sync_r <= {sync_r[SYNC_STAGES-2:0], notifier};
            prev   <= sync_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ts_ctr   <= '0;
            viol_cnt <= '0;
            viol_sat <= 1'b0;
            first_ts <= '0;
            ts_valid <= 1'b0;
        end else if (clr) begin
            ts_ctr   <= '0;
            viol_cnt <= '0;
            viol_sat <= 1'b0;
            first_ts <= '0;
            ts_valid <= 1'b0;
        end else begin
            ts_ctr <= ts_ctr + TS_W'(1);
            if (viol_evt) begin
                if (!ts_valid) begin
                    first_ts <= ts_ctr;
                    ts_valid <= 1'b1;
                end
                if (viol_cnt != CNT_MAX) viol_cnt <= viol_cnt + CNT_W'(1);
                if (viol_cnt == CNT_PRE) viol_sat <= 1'b1;
            end
        end
    end

    // An ack coinciding with a fresh event keeps PENDING so the new interrupt is not lost.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            irq   <= 1'b0;
        end else if (clr) begin
            state <= en ? ARMED : IDLE;
            irq   <= 1'b0;
        end else if (!en) begin
            state <= IDLE;
            irq   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    state <= ARMED;
                    irq   <= 1'b0;
                end
                ARMED: begin
                    if (viol_evt) begin
                        state <= PENDING;
                        irq   <= 1'b1;
                    end
                end
                PENDING: begin
                    if (irq_ack && !viol_evt) begin
                        state <= ARMED;
                        irq   <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    irq   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tchk_notifier_monitor.sv
// Bench for tchk_notifier_monitor: directed scenarios plus random traffic, all checked
// against a notifier-history reference model evaluated every clock edge.
module tb_tchk_notifier_monitor;

    localparam int S = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        notifier = 1'b0;
    logic        en = 1'b0;
    logic        clr = 1'b0;
    logic        irq_ack = 1'b0;
    logic [7:0]  viol_cnt;
    logic        viol_sat;
    logic [15:0] first_ts;
    logic        ts_valid;
    logic        irq;

    int n_checks = 0;
    int n_err    = 0;

    tchk_notifier_monitor #(.CNT_W(8), .TS_W(16), .SYNC_STAGES(S)) dut (
        .clk      (clk),
        .rst      (rst),
        .notifier (notifier),
        .en       (en),
        .clr      (clr),
        .irq_ack  (irq_ack),
        .viol_cnt (viol_cnt),
        .viol_sat (viol_sat),
        .first_ts (first_ts),
        .ts_valid (ts_valid),
        .irq      (irq)
    );

    always #5 clk = ~clk;

    // Reference model: hist[i] is the notifier value sampled i edges ago.
    bit          hist[$];
    logic [15:0] m_ts    = '0;
    logic [7:0]  m_cnt   = '0;
    logic [15:0] m_first = '0;
    bit          m_valid = 1'b0;
    bit          m_armed = 1'b0;
    bit          m_pend  = 1'b0;

    task automatic model_reset();
        hist.delete();
        for (int i = 0; i < S + 2; i++) hist.push_back(1'b0);
        m_ts = '0; m_cnt = '0; m_first = '0;
        m_valid = 1'b0; m_armed = 1'b0; m_pend = 1'b0;
    endtask

    task automatic model_step();
        bit ev;
        hist.push_front(notifier);
        void'(hist.pop_back());
        ev = en && !clr && (hist[S] != hist[S+1]);
        if (clr) begin
            m_ts = '0; m_cnt = '0; m_first = '0; m_valid = 1'b0;
            m_pend = 1'b0; m_armed = en;
        end else begin
            if (ev) begin
                if (!m_valid) begin
                    m_first = m_ts;
                    m_valid = 1'b1;
                end
                if (m_cnt < 8'd255) m_cnt = m_cnt + 8'd1;
            end
            m_ts = m_ts + 16'd1;
            if (!en) begin
                m_armed = 1'b0; m_pend = 1'b0;
            end else if (!m_armed) begin
                m_armed = 1'b1;
            end else if (ev) begin
                m_pend = 1'b1;
            end else if (irq_ack) begin
                m_pend = 1'b0;
            end
        end
    endtask

    initial model_reset();

    always @(posedge clk or posedge rst) begin
        if (rst) model_reset();
        else     model_step();
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_model();
        check("viol_cnt", 32'(viol_cnt), 32'(m_cnt));
        check("viol_sat", 32'(viol_sat), 32'(m_cnt == 8'hFF));
        check("first_ts", 32'(first_ts), 32'(m_first));
        check("ts_valid", 32'(ts_valid), 32'(m_valid));
        check("irq",      32'(irq),      32'(m_pend));
    endtask

    // Drive inputs for the next edge, then sample on the following falling edge.
    task automatic cycle(input bit n, input bit e, input bit c, input bit a);
        notifier = n; en = e; clr = c; irq_ack = a;
        @(negedge clk);
        check_model();
    endtask

    bit nv = 1'b0;

    initial begin
        // Reset from 1 to 3 ns; edge 1 at 5 ns.
        en = 1'b1;
        #1 rst = 1'b1;
        #2 rst = 1'b0;
        #1;
        check("rst_cnt",   32'(viol_cnt), 32'd0);
        check("rst_irq",   32'(irq),      32'd0);
        check("rst_valid", 32'(ts_valid), 32'd0);
        check("rst_ts",    32'(first_ts), 32'd0);

        // Scenario 1: notifier rises before edge 10, counted after edge 12.
        for (int i = 1; i <= 9; i++) cycle(1'b0, 1'b1, 1'b0, 1'b0);
        nv = 1'b1;
        cycle(nv, 1'b1, 1'b0, 1'b0);
        cycle(nv, 1'b1, 1'b0, 1'b0);
        check("s1_latency_cnt", 32'(viol_cnt), 32'd0);
        cycle(nv, 1'b1, 1'b0, 1'b0);
        check("s1_cnt",   32'(viol_cnt), 32'd1);
        check("s1_irq",   32'(irq),      32'd1);
        check("s1_valid", 32'(ts_valid), 32'd1);
        check("s1_ts",    32'(first_ts), 32'd11);

        // Scenario 2: 300 toggles saturate the counter, further toggles hold it.
        for (int i = 0; i < 300; i++) begin
            nv = ~nv;
            cycle(nv, 1'b1, 1'b0, 1'b0);
            cycle(nv, 1'b1, 1'b0, 1'b0);
        end
        cycle(nv, 1'b1, 1'b0, 1'b0);
        check("s2_cnt", 32'(viol_cnt), 32'd255);
        check("s2_sat", 32'(viol_sat), 32'd1);
        for (int i = 0; i < 6; i++) begin
            nv = ~nv;
            cycle(nv, 1'b1, 1'b0, 1'b0);
            cycle(nv, 1'b1, 1'b0, 1'b0);
        end
        cycle(nv, 1'b1, 1'b0, 1'b0);
        check("s2_hold", 32'(viol_cnt), 32'd255);
        check("s2_first_kept", 32'(first_ts), 32'd11);

        // Scenario 3: ack coinciding with an event keeps irq; a lone ack clears it.
        cycle(nv, 1'b1, 1'b1, 1'b0);
        nv = ~nv;
        cycle(nv, 1'b1, 1'b0, 1'b0);
        cycle(nv, 1'b1, 1'b0, 1'b0);
        cycle(nv, 1'b1, 1'b0, 1'b0);
        check("s3_pend_irq", 32'(irq), 32'd1);
        nv = ~nv;
        cycle(nv, 1'b1, 1'b0, 1'b0);
        cycle(nv, 1'b1, 1'b0, 1'b0);
        cycle(nv, 1'b1, 1'b0, 1'b1);
        check("s3_ack_evt_irq", 32'(irq),      32'd1);
        check("s3_ack_evt_cnt", 32'(viol_cnt), 32'd2);
        cycle(nv, 1'b1, 1'b0, 1'b0);
        cycle(nv, 1'b1, 1'b0, 1'b1);
        check("s3_lone_ack", 32'(irq), 32'd0);
        cycle(nv, 1'b1, 1'b0, 1'b1);
        check("s3_ack_idle", 32'(irq), 32'd0);

        // Scenario 4: toggles while disabled are not counted after re-enable.
        cycle(nv, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) begin
            nv = ~nv;
            cycle(nv, 1'b0, 1'b0, 1'b0);
            cycle(nv, 1'b0, 1'b0, 1'b0);
        end
        for (int i = 0; i < 4; i++) cycle(nv, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 6; i++) cycle(nv, 1'b1, 1'b0, 1'b0);
        check("s4_cnt",   32'(viol_cnt), 32'd0);
        check("s4_irq",   32'(irq),      32'd0);
        check("s4_valid", 32'(ts_valid), 32'd0);

        // Scenario 5: clr coinciding with an event drops that event.
        for (int i = 0; i < 3; i++) begin
            nv = ~nv;
            cycle(nv, 1'b1, 1'b0, 1'b0);
            cycle(nv, 1'b1, 1'b0, 1'b0);
        end
        cycle(nv, 1'b1, 1'b0, 1'b0);
        check("s5_pre_cnt", 32'(viol_cnt), 32'd3);
        nv = ~nv;
        cycle(nv, 1'b1, 1'b0, 1'b0);
        cycle(nv, 1'b1, 1'b0, 1'b0);
        cycle(nv, 1'b1, 1'b1, 1'b0);
        check("s5_clr_cnt",   32'(viol_cnt), 32'd0);
        check("s5_clr_valid", 32'(ts_valid), 32'd0);
        check("s5_clr_irq",   32'(irq),      32'd0);
        nv = ~nv;
        cycle(nv, 1'b1, 1'b0, 1'b0);
        cycle(nv, 1'b1, 1'b0, 1'b0);
        cycle(nv, 1'b1, 1'b0, 1'b0);
        check("s5_next_cnt", 32'(viol_cnt), 32'd1);
        check("s5_next_irq", 32'(irq),      32'd1);

        // Scenario 6: reset between edges while irq is high acts immediately.
        #2 rst = 1'b1;
        #1;
        check("s6_irq",   32'(irq),      32'd0);
        check("s6_cnt",   32'(viol_cnt), 32'd0);
        check("s6_valid", 32'(ts_valid), 32'd0);
        #1 rst = 1'b0;
        for (int i = 0; i < 6; i++) cycle(nv, 1'b1, 1'b0, 1'b0);

        // Random traffic against the model.
        for (int i = 0; i < 1500; i++) begin
            bit e, c, a;
            if ($urandom_range(2) == 0) nv = ~nv;
            e = ($urandom_range(19) != 0);
            c = ($urandom_range(39) == 0);
            a = ($urandom_range(4) == 0);
            cycle(nv, e, c, a);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
